link_printer: RTL and testbench
===============================

Name: link_printer

Overview:
- Emulated Game Boy Printer that sits on the far end of the console link-cable port.
- It is always the external-clock slave. It samples the console's serial clock, receives packets MSB-first and drives response bytes back.
- It decodes printer commands and forwards image bytes and print requests to the frame-buffer/print backend.
- It shares `clk`/`cpu_en` with the console so that edge detection matches the serial port's tick.

Parameters:
TIMEOUT, 4096, cpu_en ticks without an sclk edge (mid-packet) before parser aborts to IDLE
PRINT_TICKS, 65536, cpu_en ticks the busy status bit stays set after a print
BUF_BYTES, 5760, accumulated data-byte count at which status "buffer full" sets

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cpu_en  in  1  clock enable; all state advances only when high
sclk  in  1  link clock driven by console (idle high)
sin  in  1  console serial out
sout  out  1  serial data to console
byte_valid  out  1  one-cycle strobe per image data byte
byte_data  out  8  image data byte
init_pulse  out  1  one-cycle strobe: valid INIT packet
print_start  out  1  one-cycle strobe: valid PRINT accepted
print_params  out  32  {p0,p1,p2,p3} print args, p0 in [31:24]
pkt_done  out  1  one-cycle strobe at end of checksum-high byte
pkt_ok  out  1  checksum match qualifier, valid with pkt_done
status  out  8  current status register

Interface: one clock (`clk`); `reset` is synchronous and active-high.

Behaviour:
- Edge detect:
  - `sclk_prev` resets to 1 and updates only on `cpu_en`.
  - Falling edge = `cpu_en & sclk_prev & ~sclk`; rising edge = `cpu_en & ~sclk_prev & sclk`.
- Bit timing:
  - On falling edge, `sout <= tx[7]` and tx shifts left.
  - On rising edge, `rx <= {rx[6:0], sin}` and the 3-bit bit counter increments.
  - The 8th rising edge (counter 7→0) completes a byte.
  - In the same cycle, tx loads the next response byte: 0x81 if the completed byte was CHK_H, the status register if it was ACK, else 0x00.
- Reset values:
  - `sout`=0, tx=0, rx=0, bit counter=0, state=IDLE, status=0x00.
  - All strobes 0, `print_params`=0, `byte_data`=0, data count=0, busy counter=0, timeout counter=0.
- States (advance on byte completion):
  - IDLE: 0x88 → MAGIC2; any other byte → stay.
  - MAGIC2: 0x33 → CMD; 0x88 → stay; any other byte → IDLE.
  - CMD: latch cmd; checksum = byte.
  - COMP: checksum += byte.
  - LEN_L, LEN_H: latch 16-bit len; checksum += byte. After LEN_H go DATA if len≠0, else CHK_L.
  - DATA: checksum += byte; remaining decrements; at 0 → CHK_L.
    - cmd=0x04: `byte_valid`/`byte_data` strobe in the completion cycle; data count increments (saturating at 16 bits).
    - cmd=0x02: bytes 0-3 shift into the param shadow.
  - CHK_L → CHK_H.
  - CHK_H: compare {CHK_H,CHK_L} with the 16-bit wrap-around checksum; strobe `pkt_done`, `pkt_ok`; then → ACK.
  - ACK (console receives 0x81) → STAT.
  - STAT (console receives status) → IDLE.
- Checksum is a 16-bit sum with wrap-around; magic bytes are excluded.
- Command actions, applied at CHK_H completion only when `pkt_ok`=1:
  - 0x01 INIT: `init_pulse`; status=0; data count=0; busy counter=0.
  - 0x02 PRINT:
    - Accepted only when len==4 and not busy. On accept: `print_start`, `print_params` updated, busy counter=PRINT_TICKS, status[3]=0, data count=0.
    - Otherwise ignored, no strobe.
  - 0x04 DATA: if len≠0, status[3]=1.
  - 0x0F and other codes: no action.
- Status bits: [0] checksum error of last packet (set/cleared every `pkt_done`), [1] busy counter≠0, [2] data count ≥ BUF_BYTES, [3] unprocessed data; others 0.
- The status byte sent in STAT reflects the post-action values.
- Busy counter decrements on `cpu_en` while nonzero.
- Timeout:
  - The counter clears on any sclk edge and counts `cpu_en` ticks while state≠IDLE or bit counter≠0.
  - At TIMEOUT: state=IDLE, bit counter=0, tx=0x00. Status and `sout` are unchanged.
- Simultaneous events:
  - Timeout and an edge in the same cycle: the edge wins.
  - Reset mid-byte: full reset; the partially received byte is discarded.
- Data bytes are forwarded before checksum verification; the backend discards them on `pkt_done` with `pkt_ok`=0.

Test Plan:
- INIT packet 88 33 01 00 00 00 01 00 00 00 → `sout` returns 00×8, then 81, 00; `init_pulse` and `pkt_done`/`pkt_ok`=1 at the 8th byte; `status`=0x00.
- DATA packet 88 33 04 00 02 00 AA 55 05 01 00 00 → `byte_valid` twice (AA, 55); `pkt_ok`=1; 10th byte response 81; status byte 0x08.
- Same DATA packet with checksum 06 01 → `pkt_ok`=0; status byte 0x01; status[3] stays 0.
- After a good DATA packet, PRINT packet 88 33 02 00 04 00 01 13 E4 40 3E 01 00 00 → `print_start`, `print_params`=0x0113E440, status byte 0x02. A status packet (cmd 0F, chk 0F 00) after PRINT_TICKS returns 0x00.
- Send 88 33 01, then stall sclk for TIMEOUT+1 `cpu_en` ticks → state IDLE; a following full INIT packet is processed normally. Also: 88 88 33 prefix is accepted as resync.
- Assert `reset` after 4 bits of a byte → all outputs at reset values; the next full packet decodes with correct bit alignment.

Source files
------------

// File: rtl/link_printer.sv
// link_printer: Game Boy Printer emulation on the slave side of the link cable
module link_printer #(
    parameter int TIMEOUT     = 4096,
    parameter int PRINT_TICKS = 65536,
    parameter int BUF_BYTES   = 5760
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        sclk,
    input  logic        sin,
    output logic        sout,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        init_pulse,
    output logic        print_start,
    output logic [31:0] print_params,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [7:0]  status
);
    localparam int BW = $clog2(PRINT_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] MAGIC2 = 4'd1;
    localparam logic [3:0] CMD    = 4'd2;
    localparam logic [3:0] COMP   = 4'd3;
    localparam logic [3:0] LEN_L  = 4'd4;
    localparam logic [3:0] LEN_H  = 4'd5;
    localparam logic [3:0] DATA   = 4'd6;
    localparam logic [3:0] CHK_L  = 4'd7;
    localparam logic [3:0] CHK_H  = 4'd8;
    localparam logic [3:0] ACK    = 4'd9;
    localparam logic [3:0] STAT   = 4'd10;

    logic          sclk_prev;
    logic [7:0]    tx, rx;
    logic [2:0]    bit_cnt;
    logic [3:0]    state;
    logic [7:0]    cmd, chk_l;
    logic [15:0]   chk, len, idx, data_cnt;
    logic [31:0]   shadow;
    logic [BW-1:0] busy_cnt;
    logic [TW-1:0] to_cnt;
    logic          chk_err, unproc;

    logic       fall, rise, byte_done, counting, abort, ok;
    logic [7:0] nb;

    assign fall      = cpu_en & sclk_prev & ~sclk;
    assign rise      = cpu_en & ~sclk_prev & sclk;
    assign byte_done = rise & (bit_cnt == 3'd7);
    assign nb        = {rx[6:0], sin};
    assign counting  = (state != IDLE) || (bit_cnt != 3'd0);
    // an sclk edge always beats an expiring timeout, so edges are excluded here
    assign abort     = cpu_en & ~fall & ~rise & counting & (to_cnt == TW'(TIMEOUT - 1));
    assign ok        = {nb, chk_l} == chk;
    assign status    = {4'b0, unproc, data_cnt >= 16'(BUF_BYTES), busy_cnt != '0, chk_err};

    // serial shifter: edge detection, bit exchange, response loading and the stall watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_prev <= 1'b1;
            sout      <= 1'b0;
            tx        <= 8'h00;
            rx        <= 8'h00;
            bit_cnt   <= 3'd0;
            to_cnt    <= '0;
        end else begin
            if (cpu_en) sclk_prev <= sclk;
            to_cnt <= (fall | rise | abort | ~counting) ? '0 : cpu_en ? to_cnt + 1'b1 : to_cnt;
            if (fall) begin
                sout <= tx[7];
                tx   <= {tx[6:0], 1'b0};
            end
            if (rise) begin
                rx      <= nb;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) tx <= (state == CHK_H) ? 8'h81 : (state == ACK) ? status : 8'h00;
            end
            if (abort) begin
                bit_cnt <= 3'd0;
                tx      <= 8'h00;
            end
        end
    end

    // packet parser, checksum, command actions and status bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd          <= 8'h00;
            chk          <= 16'h0000;
            chk_l        <= 8'h00;
            len          <= 16'h0000;
            idx          <= 16'h0000;
            shadow       <= 32'h0;
            byte_valid   <= 1'b0;
            byte_data    <= 8'h00;
            init_pulse   <= 1'b0;
            print_start  <= 1'b0;
            print_params <= 32'h0;
            pkt_done     <= 1'b0;
            pkt_ok       <= 1'b0;
            data_cnt     <= 16'h0000;
            busy_cnt     <= '0;
            chk_err      <= 1'b0;
            unproc       <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            init_pulse  <= 1'b0;
            print_start <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_ok      <= 1'b0;
            if (cpu_en && busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
            if (abort) begin
                state <= IDLE;
            end else if (byte_done) begin
                case (state)
                    IDLE:   state <= (nb == 8'h88) ? MAGIC2 : IDLE;
                    MAGIC2: state <= (nb == 8'h33) ? CMD : (nb == 8'h88) ? MAGIC2 : IDLE;
                    CMD: begin
                        cmd   <= nb;
                        chk   <= {8'h00, nb};
                        state <= COMP;
                    end
                    COMP: begin
                        chk   <= chk + {8'h00, nb};
                        state <= LEN_L;
                    end
                    LEN_L: begin
                        len[7:0] <= nb;
                        chk      <= chk + {8'h00, nb};
                        state    <= LEN_H;
                    end
                    LEN_H: begin
                        len[15:8] <= nb;
                        chk       <= chk + {8'h00, nb};
                        idx       <= 16'h0000;
                        state     <= ({nb, len[7:0]} != 16'h0000) ? DATA : CHK_L;
                    end
                    DATA: begin
                        chk <= chk + {8'h00, nb};
                        idx <= idx + 16'd1;
                        if (cmd == 8'h04) begin
                            byte_valid <= 1'b1;
                            byte_data  <= nb;
                            if (data_cnt != 16'hFFFF) data_cnt <= data_cnt + 16'd1;
                        end
                        if (cmd == 8'h02 && idx < 16'd4) shadow <= {shadow[23:0], nb};
                        if (idx + 16'd1 == len) state <= CHK_L;
                    end
                    CHK_L: begin
                        chk_l <= nb;
                        state <= CHK_H;
                    end
                    CHK_H: begin
                        pkt_done <= 1'b1;
                        pkt_ok   <= ok;
                        chk_err  <= ~ok;
                        state    <= ACK;
                        if (ok && cmd == 8'h01) begin
                            init_pulse <= 1'b1;
                            unproc     <= 1'b0;
                            data_cnt   <= 16'h0000;
                            busy_cnt   <= '0;
                        end
                        if (ok && cmd == 8'h02 && len == 16'd4 && busy_cnt == '0) begin
                            print_start  <= 1'b1;
                            print_params <= shadow;
                            busy_cnt     <= BW'(PRINT_TICKS);
                            unproc       <= 1'b0;
                            data_cnt     <= 16'h0000;
                        end
                        if (ok && cmd == 8'h04 && len != 16'h0000) unproc <= 1'b1;
                    end
                    ACK:     state <= STAT;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_link_printer.sv
// tb_link_printer: directed packet-level bench for the link cable printer
module tb_link_printer;
    logic        clk = 1'b0;
    logic        reset, cpu_en, sclk, sin;
    logic        sout, byte_valid, init_pulse, print_start, pkt_done, pkt_ok;
    logic [7:0]  byte_data, status;
    logic [31:0] print_params;

    always #5 clk = ~clk;

    link_printer #(.TIMEOUT(64), .PRINT_TICKS(3000), .BUF_BYTES(3)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .sclk(sclk), .sin(sin),
        .sout(sout), .byte_valid(byte_valid), .byte_data(byte_data),
        .init_pulse(init_pulse), .print_start(print_start), .print_params(print_params),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .status(status)
    );

    int tests = 0;
    int failed = 0;
    int n_init = 0, n_done = 0, n_print = 0, n_valid = 0;
    int init_at = -1, done_at = -1;
    logic last_ok = 1'b0;
    logic [15:0] vbytes = 16'h0;
    int byte_idx = 0;
    int i0, d0, p0, v0;
    logic [7:0] q[$];
    logic [7:0] resp[$];
    logic [7:0] dummy;

    // strobe monitor, sampled on the falling clock edge
    always @(negedge clk) begin
        if (init_pulse) begin
            n_init++;
            init_at = byte_idx;
        end
        if (pkt_done) begin
            n_done++;
            last_ok = pkt_ok;
            done_at = byte_idx;
        end
        if (print_start) n_print++;
        if (byte_valid) begin
            n_valid++;
            vbytes = {vbytes[7:0], byte_data};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sclk = 1'b0;
            repeat (3) @(posedge clk);
            #1 r[i] = sout;
            sin = b[i];
            sclk = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic send();
        logic [7:0] r;
        resp.delete();
        byte_idx = 0;
        i0 = n_init; d0 = n_done; p0 = n_print; v0 = n_valid;
        foreach (q[k]) begin
            xfer(q[k], 8, r);
            resp.push_back(r);
            byte_idx++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input string tag, input logic [7:0] st);
        int nz;
        nz = 0;
        send();
        for (int k = 0; k < resp.size() - 2; k++) if (resp[k] != 8'h00) nz++;
        check({tag, "_zero_resp"}, nz, 0);
        check({tag, "_ack"}, resp[resp.size() - 2], 8'h81);
        check({tag, "_stat_byte"}, resp[resp.size() - 1], st);
        check({tag, "_status"}, status, st);
    endtask

    initial begin
        reset = 1'b1; cpu_en = 1'b1; sclk = 1'b1; sin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sout", sout, 0);
        check("rst_status", status, 8'h00);
        check("rst_params", print_params, 32'h0);
        check("rst_strobes", {byte_valid, init_pulse, print_start, pkt_done, pkt_ok}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        q = '{8'h88, 8'h33, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_chk("init", 8'h00);
        check("init_pulse", n_init - i0, 1);
        check("init_at", init_at, 7);
        check("init_done_at", done_at, 7);
        check("init_ok", last_ok, 1);

        q = '{8'h88, 8'h33, 8'h04, 8'h00, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h06, 8'h01, 8'h00, 8'h00};
        send_chk("bad_data", 8'h01);
        check("bad_data_ok", last_ok, 0);
        check("bad_data_done", n_done - d0, 1);
        check("bad_data_valid", n_valid - v0, 2);

        q = '{8'h88, 8'h33, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_chk("init2", 8'h00);

        q = '{8'h88, 8'h33, 8'h04, 8'h00, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h05, 8'h01, 8'h00, 8'h00};
        send_chk("data", 8'h08);
        check("data_ok", last_ok, 1);
        check("data_valid", n_valid - v0, 2);
        check("data_bytes", vbytes, 16'hAA55);
        check("data_done_at", done_at, 9);
        check("data_byte_out", byte_data, 8'h55);

        send_chk("data_full", 8'h0C);

        q = '{8'h88, 8'h33, 8'h02, 8'h00, 8'h04, 8'h00, 8'h01, 8'h13, 8'hE4, 8'h40, 8'h3E, 8'h01, 8'h00, 8'h00};
        send_chk("print", 8'h02);
        check("print_start", n_print - p0, 1);
        check("print_params", print_params, 32'h0113E440);

        q = '{8'h88, 8'h33, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00, 8'h13, 8'hE4, 8'h40, 8'h3D, 8'h01, 8'h00, 8'h00};
        send_chk("print_busy", 8'h02);
        check("print_busy_ok", last_ok, 1);
        check("print_busy_start", n_print - p0, 0);
        check("print_busy_params", print_params, 32'h0113E440);

        repeat (3000) @(posedge clk);
        #1;
        q = '{8'h88, 8'h33, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00};
        send_chk("stat_after", 8'h00);
        check("stat_after_ok", last_ok, 1);

        q = '{8'h88, 8'h33, 8'h01};
        send();
        repeat (70) @(posedge clk);
        #1;
        q = '{8'h88, 8'h33, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_chk("timeout_init", 8'h00);
        check("timeout_init_pulse", n_init - i0, 1);

        q = '{8'h88, 8'h88, 8'h33, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_chk("resync", 8'h00);
        check("resync_pulse", n_init - i0, 1);
        check("resync_at", init_at, 8);

        q = '{8'h88, 8'h33, 8'h04, 8'h00, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h06, 8'h01, 8'h00, 8'h00};
        send_chk("pre_reset", 8'h01);
        xfer(8'h88, 4, dummy);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_sout", sout, 0);
        check("mid_rst_status", status, 8'h00);
        check("mid_rst_params", print_params, 32'h0);
        check("mid_rst_byte_data", byte_data, 8'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        q = '{8'h88, 8'h33, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_chk("post_rst", 8'h00);
        check("post_rst_pulse", n_init - i0, 1);
        check("post_rst_ok", last_ok, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
